systolic_readout_quantizer: RTL and testbench
=============================================

// Module: systolic_readout_quantizer
// PURPOSE
// - Downstream of the FP4 x INT8 systolic array: consumes the serial stream of signed 24-bit accumulator
//   results shifted out of the array's output queue, one value per accepted cycle.
// - Output byte stream per value: either one requantized byte (round, shift, ReLU, saturate) or three raw bytes.
// - Decouples array readout from the byte-wide output pins through a small FIFO.
// PARAMETERS
// - ACC_W       24  accumulator width (signed)
// - DEPTH        4  FIFO depth in accumulator values (power of 2, >=2)
// - FRAME_LEN    8  values per frame (= array W*H; 8 for 2 slices)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - frame_start  in   1      opens a new frame; latches shift_amt/relu_en/raw_mode
// - shift_amt    in   5      right-shift for quantized mode; values >23 treated as 23
// - relu_en      in   1      clamp negative results to 0 (quantized mode only)
// - raw_mode     in   1      0: 1 quantized byte per value; 1: 3 raw bytes per value, LSB first
// - acc_in       in   ACC_W  accumulator value
// - acc_valid    in   1      acc_in valid
// - acc_ready    out  1      block accepts acc_in this cycle
// - out_byte     out  8      output byte
// - out_valid    out  1      out_byte valid
// - out_ready    in   1      consumer takes out_byte this cycle
// - out_last     out  1      marks final byte of the frame
// - busy         out  1      state != IDLE
// - sat_flag     out  1      sticky: saturation occurred in current frame
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty, counters 0, out_byte=0, out_valid=0, out_last=0, acc_ready=0, sat_flag=0,
//   latched config = 0.
// - States: IDLE -> (frame_start) ACTIVE -> (FRAME_LEN values accepted) FLUSH -> (out_last byte handshaken) IDLE.
// - acc_ready = (state==ACTIVE) && FIFO not full && in_count<FRAME_LEN. Accept when acc_valid && acc_ready.
// - frame_start in ACTIVE/FLUSH: FIFO flushed, out_valid cleared, counters zeroed, config relatched, sat_flag
//   cleared, state ACTIVE. frame_start takes priority over a same-cycle accept, which is dropped.
// - Output register: loads when out_valid==0 or out_ready==1, from the FIFO head. out_byte is stable while
//   out_valid && !out_ready.
// - Latency: a value accepted at cycle t with the FIFO and output register empty gives out_valid=1 at t+1.
//   Sustained throughput: 1 value/cycle (quantized mode), 1 value/3 cycles (raw mode).
// - Quantized: r = (acc + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in ACC_W+1 bits (no wrap).
//   If relu_en and r<0, r=0. Saturate to [-128,127]; set sat_flag on clamp (not on ReLU). Pop after 1 byte.
// - Raw: byte_phase 0,1,2 emits acc[7:0], acc[15:8], acc[23:16]. Pop the FIFO after phase 2. Ignores shift/relu.
// - out_last = 1 with the final byte of value FRAME_LEN-1 (phase 2 in raw mode).
// - FIFO full: acc_ready=0 and no overwrite. Pointers wrap modulo DEPTH. Simultaneous push and pop when full
//   is not possible (ready=0); when empty the push lands first and the pop happens next cycle.
// - acc_valid outside ACTIVE is ignored. Config inputs are sampled only at frame_start.
// - Reset mid-frame: all state discarded next edge; no partial bytes emitted.
// TESTING
// - Quantized, s=11, relu=0: push 0x000800, 0xFFF800, 0x7FFFFF -> bytes 0x01, 0xFF, 0x7F; sat_flag=1.
// - Rounding: s=4, push 24, 23, -24 -> 0x02, 0x01, 0xFF (-24+8=-16, >>>4 = -1). s=0, push 5 -> 0x05.
// - ReLU: s=0, relu=1, push -300, 300 -> 0x00, 0x7F; sat_flag=1 (from 300 only).
// - Raw mode: push 0x123456 with out_ready=1 -> 0x56, 0x34, 0x12 on 3 consecutive cycles.
//   With FRAME_LEN=8, out_last only on the 24th byte.
// - Backpressure: out_ready=0, push 5 values -> 4 accepted (1 in output reg + DEPTH-1 in FIFO, then full),
//   acc_ready=0 after that. Release -> all bytes in order, none lost or duplicated.
// - frame_start mid-frame after 3 values, and reset during FLUSH -> old data never appears.
//   Next frame's first byte is correct; busy returns to 0 after out_last.

Source files
------------

// File: rtl/systolic_readout_quantizer.sv
// Readout stage behind the systolic array: buffers signed accumulators in a small FIFO and
// emits either one requantized byte or three raw bytes per value on a byte-wide stream.
module systolic_readout_quantizer #(
    parameter int ACC_W     = 24,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start_i,
    input  logic [4:0]       shift_amt_i,
    input  logic             relu_en_i,
    input  logic             raw_mode_i,
    input  logic [ACC_W-1:0] acc_in_i,
    input  logic             acc_valid_i,
    output logic             acc_ready_o,
    output logic [7:0]       out_byte_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             sat_flag_o
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(FRAME_LEN + 1);
    localparam int RAW_N = (ACC_W + 7) / 8;
    localparam logic [4:0] SH_MAX = 5'(ACC_W - 1);
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-128);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic             sat_q, sat_d;
    logic [4:0]       cfg_shift_q, cfg_shift_d;
    logic             cfg_relu_q, cfg_relu_d, cfg_raw_q, cfg_raw_d;

    logic fifo_empty, fifo_full, push, last_value;
    logic [ACC_W-1:0]       head;
    logic [8*RAW_N-1:0]     head_pad;
    logic [4:0]             sh;
    logic signed [ACC_W:0]  ext, rnd, sum, res;
    logic [7:0]             q_byte;
    logic                   q_sat;

    // Pointers wrap naturally; one slot stays unused so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (PW'(wr_ptr_q + 1'b1) == rd_ptr_q);
    assign push       = acc_valid_i && acc_ready_o && !frame_start_i;
    assign head       = mem_q[rd_ptr_q];
    assign head_pad   = (8*RAW_N)'(head);
    assign last_value = (pop_cnt_q == CW'(FRAME_LEN - 1));

    // Round-half-up then arithmetic shift in ACC_W+1 bits so the rounding add never wraps.
    always_comb begin
        sh = (cfg_shift_q > SH_MAX) ? SH_MAX : cfg_shift_q;
        ext = $signed({head[ACC_W-1], head});
        rnd = '0;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        sum = ext + rnd;
        res = sum >>> sh;
        if (cfg_relu_q && res[ACC_W]) res = '0;
        q_sat  = 1'b0;
        q_byte = res[7:0];
        if (res > Q_MAX) begin
            q_byte = 8'h7F;
            q_sat  = 1'b1;
        end else if (res < Q_MIN) begin
            q_byte = 8'h80;
            q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_start_i) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (frame_start_i) state_d = S_ACTIVE;
                else if (push && in_cnt_q == CW'(FRAME_LEN - 1)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (frame_start_i) state_d = S_ACTIVE;
                else if (out_valid_q && out_ready_i && out_last_q) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        acc_ready_o = (state_q == S_ACTIVE) && !fifo_full && (in_cnt_q < CW'(FRAME_LEN));
        out_byte_o  = out_byte_q;
        out_valid_o = out_valid_q;
        out_last_o  = out_last_q;
        sat_flag_o  = sat_q;
    end

    // valid/ready: a byte transfers on any edge where out_valid_o && out_ready_i; the output
    // register only reloads when empty or being taken, so a stalled byte never changes.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        in_cnt_d    = in_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        phase_d     = phase_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;
        cfg_shift_d = cfg_shift_q;
        cfg_relu_d  = cfg_relu_q;
        cfg_raw_d   = cfg_raw_q;
        if (frame_start_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            in_cnt_d    = '0;
            pop_cnt_d   = '0;
            phase_d     = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            sat_d       = 1'b0;
            cfg_shift_d = shift_amt_i;
            cfg_relu_d  = relu_en_i;
            cfg_raw_d   = raw_mode_i;
        end else begin
            if (push) begin
                wr_ptr_d = PW'(wr_ptr_q + 1'b1);
                in_cnt_d = CW'(in_cnt_q + 1'b1);
            end
            if (!out_valid_q || out_ready_i) begin
                out_valid_d = !fifo_empty;
                out_last_d  = 1'b0;
                if (!fifo_empty) begin
                    if (cfg_raw_q) begin
                        out_byte_d = head_pad[8*phase_q +: 8];
                        if (phase_q == 2'(RAW_N - 1)) begin
                            phase_d    = '0;
                            rd_ptr_d   = PW'(rd_ptr_q + 1'b1);
                            pop_cnt_d  = CW'(pop_cnt_q + 1'b1);
                            out_last_d = last_value;
                        end else begin
                            phase_d = 2'(phase_q + 1'b1);
                        end
                    end else begin
                        out_byte_d = q_byte;
                        sat_d      = sat_q | q_sat;
                        rd_ptr_d   = PW'(rd_ptr_q + 1'b1);
                        pop_cnt_d  = CW'(pop_cnt_q + 1'b1);
                        out_last_d = last_value;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= acc_in_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_cnt_q    <= '0;
            pop_cnt_q   <= '0;
            phase_q     <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            cfg_shift_q <= '0;
            cfg_relu_q  <= 1'b0;
            cfg_raw_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_cnt_q    <= in_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            phase_q     <= phase_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            cfg_shift_q <= cfg_shift_d;
            cfg_relu_q  <= cfg_relu_d;
            cfg_raw_q   <= cfg_raw_d;
        end
    end
endmodule

// File: tb/tb_systolic_readout_quantizer.sv
// Bench for systolic_readout_quantizer: directed cases plus random frames against an
// arithmetic reference model and an expected-byte queue.
module tb_systolic_readout_quantizer;
    localparam int ACC_W     = 24;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_start_i;
    logic [4:0]       shift_amt_i;
    logic             relu_en_i;
    logic             raw_mode_i;
    logic [ACC_W-1:0] acc_in_i;
    logic             acc_valid_i;
    logic             acc_ready_o;
    logic [7:0]       out_byte_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;
    logic             busy_o;
    logic             sat_flag_o;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;  // 0: stall, 1: always ready, 2: random

    logic [8:0] exp_q[$];  // {last, byte}
    int   m_shift;
    bit   m_relu, m_raw, m_sat;
    int   m_idx;
    bit   prev_stall;
    logic [7:0] prev_byte;

    systolic_readout_quantizer #(.ACC_W(ACC_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .reset(reset), .frame_start_i(frame_start_i), .shift_amt_i(shift_amt_i),
        .relu_en_i(relu_en_i), .raw_mode_i(raw_mode_i), .acc_in_i(acc_in_i),
        .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .out_byte_o(out_byte_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o),
        .busy_o(busy_o), .sat_flag_o(sat_flag_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: divide by 2^s with floor, after adding half an LSB; then ReLU and clamp.
    function automatic logic [8:0] model_q(input logic [23:0] v, input int s_in, input bit relu);
        int a, s, d, num, r;
        bit sat;
        a = int'($signed(v));
        s = (s_in > 23) ? 23 : s_in;
        d = 1 << s;
        num = a + ((s > 0) ? d / 2 : 0);
        r = (num >= 0) ? num / d : -((-num + d - 1) / d);
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > 127) begin r = 127; sat = 1'b1; end
        if (r < -128) begin r = -128; sat = 1'b1; end
        return {sat, 8'(r)};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = (rdy_mode == 1) ? 1'b1 :
                          (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: inputs only change just after posedge, so the negedge sees what the edge will take.
    always @(negedge clk) begin
        logic [8:0] q, e;
        bit lastv;
        if (reset) begin
            exp_q.delete();
            prev_stall = 0;
            m_sat = 0; m_idx = 0; m_shift = 0; m_relu = 0; m_raw = 0;
        end else if (frame_start_i) begin
            exp_q.delete();
            prev_stall = 0;
            m_shift = int'(shift_amt_i); m_relu = relu_en_i; m_raw = raw_mode_i;
            m_sat = 0; m_idx = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid_o, 1);
                check("hold_byte", out_byte_o, prev_byte);
            end
            if (acc_valid_i && acc_ready_o) begin
                lastv = (m_idx == FRAME_LEN - 1);
                if (m_raw) begin
                    for (int b = 0; b < 3; b++)
                        exp_q.push_back({lastv && (b == 2), acc_in_i[8*b +: 8]});
                end else begin
                    q = model_q(acc_in_i, m_shift, m_relu);
                    m_sat = m_sat | q[8];
                    exp_q.push_back({lastv, q[7:0]});
                end
                m_idx++;
            end
            if (out_valid_o && out_ready_i) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_byte", out_byte_o, e[7:0]);
                    check("out_last", out_last_o, e[8]);
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_byte  = out_byte_o;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_frame(input int s, input bit relu, input bit raw);
        frame_start_i = 1'b1;
        shift_amt_i   = 5'(s);
        relu_en_i     = relu;
        raw_mode_i    = raw;
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        shift_amt_i   = 5'($urandom_range(0, 31));
        relu_en_i     = 1'($urandom_range(0, 1));
        raw_mode_i    = 1'($urandom_range(0, 1));
    endtask

    task automatic push_val(input logic [23:0] v);
        int n = 0;
        acc_in_i    = v;
        acc_valid_i = 1'b1;
        @(negedge clk);
        while (!acc_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", n < 200, 1);
        @(posedge clk);
        #1;
        acc_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid_o) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", n < 1000, 1);
    endtask

    function automatic logic [23:0] rand_acc();
        if ($urandom_range(0, 2) == 0) return 24'($urandom);
        return 24'(int'($urandom_range(0, 1000)) - 500);
    endfunction

    initial begin
        int acc_cnt, n;
        frame_start_i = 0; shift_amt_i = 0; relu_en_i = 0; raw_mode_i = 0;
        acc_in_i = 0; acc_valid_i = 0; out_ready_i = 1;
        do_reset();
        check("rst_out_valid", out_valid_o, 0);
        check("rst_acc_ready", acc_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_sat", sat_flag_o, 0);
        check("rst_out_last", out_last_o, 0);
        check("rst_out_byte", out_byte_o, 0);

        acc_valid_i = 1'b1;
        acc_in_i    = 24'h000777;
        @(negedge clk);
        check("idle_no_ready", acc_ready_o, 0);
        @(posedge clk);
        #1;
        acc_valid_i = 1'b0;

        // Quantize with saturation
        start_frame(11, 0, 0);
        check("busy_active", busy_o, 1);
        push_val(24'h000800);
        push_val(24'hFFF800);
        push_val(24'h7FFFFF);
        drain();
        check("sat_s11", sat_flag_o, 1);

        // Rounding
        start_frame(4, 0, 0);
        check("sat_cleared", sat_flag_o, 0);
        push_val(24'd24);
        push_val(24'd23);
        push_val(24'(-24));
        drain();
        check("sat_round", sat_flag_o, 0);
        start_frame(0, 0, 0);
        push_val(24'd5);
        @(negedge clk);
        @(negedge clk);
        check("latency_valid", out_valid_o, 1);
        drain();

        // ReLU clamp does not count as saturation
        start_frame(0, 1, 0);
        push_val(24'(-300));
        drain();
        check("sat_relu_only", sat_flag_o, 0);
        push_val(24'd300);
        drain();
        check("sat_relu_300", sat_flag_o, 1);

        // Raw mode: three consecutive bytes, out_last on byte 24
        start_frame(0, 0, 1);
        push_val(24'h123456);
        n = 0;
        while (!out_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("raw_first", out_valid_o, 1);
        @(negedge clk);
        check("raw_second", out_valid_o, 1);
        @(negedge clk);
        check("raw_third", out_valid_o, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < FRAME_LEN - 1; i++) push_val(rand_acc());
        drain();
        check("raw_idle", busy_o, 0);

        // Backpressure: output register plus DEPTH-1 FIFO slots
        start_frame(0, 0, 0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            acc_in_i    = 24'(10 * i + 1);
            acc_valid_i = 1'b1;
            @(negedge clk);
            if (acc_ready_o) acc_cnt++;
            @(posedge clk);
            #1;
        end
        acc_valid_i = 1'b0;
        check("bp_accepted", acc_cnt, 4);
        check("bp_ready_low", acc_ready_o, 0);
        check("bp_out_valid", out_valid_o, 1);
        rdy_mode = 1;
        drain();

        // Restart mid-frame: stale bytes must vanish
        start_frame(5, 0, 0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_val(rand_acc());
        start_frame(2, 0, 0);
        rdy_mode = 2;
        for (int i = 0; i < FRAME_LEN; i++) push_val(rand_acc());
        drain();
        check("restart_idle", busy_o, 0);

        // Reset during FLUSH
        start_frame(3, 0, 1);
        rdy_mode = 2;
        for (int i = 0; i < FRAME_LEN; i++) push_val(rand_acc());
        check("flush_busy", busy_o, 1);
        rdy_mode = 0;
        do_reset();
        check("rst_flush_valid", out_valid_o, 0);
        check("rst_flush_busy", busy_o, 0);
        rdy_mode = 1;
        start_frame(0, 0, 0);
        for (int i = 0; i < FRAME_LEN; i++) push_val(rand_acc());
        drain();
        check("post_rst_idle", busy_o, 0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            start_frame(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rdy_mode = 2;
            for (int i = 0; i < FRAME_LEN; i++) push_val(rand_acc());
            drain();
            check("rand_idle", busy_o, 0);
            check("rand_sat", sat_flag_o, m_sat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
